// File: rtl/sevenseg_scan_capture.sv
// Snoops a multiplexed 7-segment anode/segment/dp bus and rebuilds the per-digit hex values.
// A digit is captured once per stable window of SETTLE_CYCLES identical samples.
module sevenseg_scan_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   an_in,
   input  logic [6:0]              seg_in,
   input  logic                    dp_in,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic [NUM_DIGITS-1:0]   blank_out,
   output logic [NUM_DIGITS-1:0]   pattern_err,
   output logic                    multi_an_err,
   output logic                    frame_valid
);

   localparam int SW = NUM_DIGITS + 8;
   localparam logic [SW-1:0] INV_MASK = ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};
   localparam logic [7:0] CNT_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [7:0] CNT_FIRE = 8'(SETTLE_CYCLES - 1);

   // Sample layout is {an, seg[6:0], dp}.
   logic [SW-1:0]         sync1_q, sync2_q, prev_q, samp;
   logic [7:0]            cnt_q;
   logic                  captured_q;
   logic                  same, cap_evt;
   logic [NUM_DIGITS-1:0] cap_an;
   logic [6:0]            cap_seg;
   logic                  cap_dp;
   logic                  an_none, an_onehot;
   logic                  store_evt;
   logic                  seg_blank;
   logic [4:0]            dec;
   logic [NUM_DIGITS-1:0] mask_q, mask_d;
   logic                  multi_q, frame_q;

   function automatic logic [4:0] hex_decode(input logic [6:0] s);
      // Returns {valid, nibble}; anything outside the 16 glyphs is invalid.
      case (s)
         7'h3F:   hex_decode = 5'h10;
         7'h06:   hex_decode = 5'h11;
         7'h5B:   hex_decode = 5'h12;
         7'h4F:   hex_decode = 5'h13;
         7'h66:   hex_decode = 5'h14;
         7'h6D:   hex_decode = 5'h15;
         7'h7D:   hex_decode = 5'h16;
         7'h07:   hex_decode = 5'h17;
         7'h7F:   hex_decode = 5'h18;
         7'h6F:   hex_decode = 5'h19;
         7'h77:   hex_decode = 5'h1A;
         7'h7C:   hex_decode = 5'h1B;
         7'h39:   hex_decode = 5'h1C;
         7'h5E:   hex_decode = 5'h1D;
         7'h79:   hex_decode = 5'h1E;
         7'h71:   hex_decode = 5'h1F;
         default: hex_decode = 5'h00;
      endcase
   endfunction

   assign samp    = sync2_q ^ INV_MASK;
   assign same    = (samp == prev_q);
   assign cap_evt = same && !captured_q && (cnt_q == CNT_FIRE);

   assign cap_an    = prev_q[SW-1:8];
   assign cap_seg   = prev_q[7:1];
   assign cap_dp    = prev_q[0];
   assign an_none   = (cap_an == '0);
   assign an_onehot = !an_none && ((cap_an & (cap_an - NUM_DIGITS'(1))) == '0);
   assign store_evt = cap_evt && an_onehot;
   assign seg_blank = (cap_seg == 7'h00);
   assign dec       = hex_decode(cap_seg);

   assign mask_d = mask_q | (store_evt ? cap_an : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         cnt_q      <= '0;
         captured_q <= 1'b0;
      end else begin
         sync1_q <= {an_in, seg_in, dp_in};
         sync2_q <= sync1_q;
         prev_q  <= samp;
         if (same) begin
            // Saturate so a long static bus never wraps into a second capture.
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 8'd1;
            if (cap_evt) captured_q <= 1'b1;
         end else begin
            cnt_q      <= '0;
            captured_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q  <= '0;
         multi_q <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         if (cap_evt && !an_none && !an_onehot) multi_q <= 1'b1;
         if (mask_d == '1) begin
            frame_q <= 1'b1;
            mask_q  <= '0;
         end else begin
            mask_q  <= mask_d;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nib_q;
      logic       dp_q, blank_q, perr_q;
      logic       hit;

      assign hit = store_evt && cap_an[gi];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            nib_q   <= '0;
            dp_q    <= 1'b0;
            blank_q <= 1'b0;
            perr_q  <= 1'b0;
         end else if (hit) begin
            dp_q <= cap_dp;
            if (seg_blank) begin
               nib_q   <= '0;
               blank_q <= 1'b1;
               perr_q  <= 1'b0;
            end else if (dec[4]) begin
               nib_q   <= dec[3:0];
               blank_q <= 1'b0;
               perr_q  <= 1'b0;
            end else begin
               // Unknown glyph: keep the last good nibble, just flag it.
               blank_q <= 1'b0;
               perr_q  <= 1'b1;
            end
         end
      end

      assign digits_out[4*gi +: 4] = nib_q;
      assign dp_out[gi]            = dp_q;
      assign blank_out[gi]         = blank_q;
      assign pattern_err[gi]       = perr_q;
   end

   assign multi_an_err = multi_q;
   assign frame_valid  = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Scoreboard bench for sevenseg_scan_capture: a reference model predicts the register state
// around each capture; a negedge monitor pops and compares when the due cycle arrives.
module tb_sevenseg_scan_capture;

   localparam int ND  = 4;
   localparam int ST  = 16;
   localparam int LAT = 2 + ST + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [ND-1:0] an_in  = '1;
   logic [6:0]    seg_in = '1;
   logic          dp_in  = 1'b1;
   logic [4*ND-1:0] digits_out;
   logic [ND-1:0] dp_out, blank_out, pattern_err;
   logic          multi_an_err, frame_valid;

   sevenseg_scan_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(ST), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in), .dp_in(dp_in),
      .digits_out(digits_out), .dp_out(dp_out), .blank_out(blank_out),
      .pattern_err(pattern_err), .multi_an_err(multi_an_err), .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      string      tag;
      logic [15:0] dig;
      logic [3:0] dp, blank, perr;
      logic       multi, fv;
   } exp_t;

   exp_t sbq[$];
   int errors = 0, checks = 0, fv_pulses = 0, m_fv_count = 0;

   logic [15:0] m_dig = '0;
   logic [3:0]  m_dp = '0, m_blank = '0, m_perr = '0, m_mask = '0;
   logic        m_multi = 1'b0;
   logic [11:0] last_in = '0;
   bit          last_valid = 1'b0;

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (frame_valid === 1'b1) fv_pulses++;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         chk({e.tag, ":digits"}, digits_out, e.dig);
         chk({e.tag, ":dp"}, dp_out, e.dp);
         chk({e.tag, ":blank"}, blank_out, e.blank);
         chk({e.tag, ":perr"}, pattern_err, e.perr);
         chk({e.tag, ":multi"}, multi_an_err, e.multi);
         chk({e.tag, ":fv"}, frame_valid, e.fv);
      end
   end

   task automatic push(input int due, input string tag, input logic fv);
      exp_t e;
      e.due = due; e.tag = tag; e.dig = m_dig; e.dp = m_dp;
      e.blank = m_blank; e.perr = m_perr; e.multi = m_multi; e.fv = fv;
      sbq.push_back(e);
   endtask

   // Reference model of one capture on an active-low bus value.
   task automatic model_capture(input logic [3:0] an_al, input logic [6:0] seg_al,
                                input logic dp_al, output logic fv);
      logic [3:0] anh;
      logic [6:0] sh;
      int idx, val;
      anh = ~an_al; sh = ~seg_al; fv = 1'b0; idx = 0; val = -1;
      if ($countones(anh) > 1) begin
         m_multi = 1'b1;
      end else if ($countones(anh) == 1) begin
         for (int i = 0; i < ND; i++) if (anh[i]) idx = i;
         for (int k = 0; k < 16; k++) if (hex_tab[k] == sh) val = k;
         m_dp[idx] = ~dp_al;
         m_mask[idx] = 1'b1;
         if (sh == 7'h00) begin
            m_dig[idx*4 +: 4] = 4'h0; m_blank[idx] = 1'b1; m_perr[idx] = 1'b0;
         end else if (val >= 0) begin
            m_dig[idx*4 +: 4] = 4'(val); m_blank[idx] = 1'b0; m_perr[idx] = 1'b0;
         end else begin
            m_blank[idx] = 1'b0; m_perr[idx] = 1'b1;
         end
         if (m_mask == 4'hF) begin
            fv = 1'b1; m_mask = '0; m_fv_count++;
         end
      end
   endtask

   task automatic drive(input logic [3:0] an_al, input logic [6:0] seg_al,
                        input logic dp_al, input int cycles, input string tag);
      logic [11:0] cur;
      logic fv;
      int n;
      @(posedge clk);
      #1;
      an_in = an_al; seg_in = seg_al; dp_in = dp_al;
      n = cyc;
      cur = {an_al, seg_al, dp_al};
      if (cycles >= LAT + 1 && !(last_valid && cur == last_in)) begin
         push(n + LAT - 1, {tag, "/pre"}, 1'b0);
         model_capture(an_al, seg_al, dp_al, fv);
         push(n + LAT, tag, fv);
         push(n + LAT + 1, {tag, "/post"}, 1'b0);
      end
      last_in = cur; last_valid = 1'b1;
      $display("drive %-10s an=%b seg=%h dp=%b hold=%0d at cycle %0d", tag, an_al, seg_al, dp_al, cycles, n);
      repeat (cycles - 1) @(posedge clk);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() > 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("drain", sbq.size(), 0);
      sbq.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ":digits"}, digits_out, 0);
      chk({tag, ":dp"}, dp_out, 0);
      chk({tag, ":blank"}, blank_out, 0);
      chk({tag, ":perr"}, pattern_err, 0);
      chk({tag, ":multi"}, multi_an_err, 0);
      chk({tag, ":fv"}, frame_valid, 0);
   endtask

   task automatic async_reset(input string tag);
      drain();
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_zero(tag);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      m_dig = '0; m_dp = '0; m_blank = '0; m_perr = '0; m_mask = '0; m_multi = 1'b0;
      last_valid = 1'b0;
      $display("reset %s at cycle %0d", tag, cyc);
   endtask

   int fv_before;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_zero("por");
      #2 rst = 1'b0;

      // Clean scan of "0b43", with the dp lit on digit 2.
      drive(4'b1110, ~7'h4F, 1'b1, 100, "scan_d0");
      drive(4'b1101, ~7'h66, 1'b1, 100, "scan_d1");
      drive(4'b1011, ~7'h7C, 1'b0, 100, "scan_d2");
      drive(4'b0111, ~7'h3F, 1'b1, 100, "scan_d3");
      drain();
      chk("scan_word", digits_out, 16'h0B43);
      chk("scan_fv_count", fv_pulses, m_fv_count);

      // Latency and glitch rejection on digit 0.
      drive(4'b1110, ~7'h06, 1'b1, 40, "lat_1");
      drive(4'b1110, ~7'h7F, 1'b1, 10, "glitch_8");
      drive(4'b1110, ~7'h06, 1'b1, 40, "lat_1b");

      // Bad glyph keeps the old nibble; all-off marks the digit blank.
      drive(4'b1011, ~7'h7F, 1'b1, 40, "d2_8");
      drive(4'b1011, ~7'h01, 1'b1, 40, "d2_bad");
      drive(4'b1101, 7'h7F, 1'b1, 40, "d1_blank");

      // Two anodes at once: sticky error, nothing stored; then scanning resumes.
      drive(4'b1100, ~7'h3F, 1'b1, 50, "multi");
      drive(4'b0111, ~7'h79, 1'b1, 40, "d3_E");
      drive(4'b1110, ~7'h4F, 1'b1, 40, "d0_3");
      drain();
      chk("multi_sticky", multi_an_err, 1);

      // Reset in the middle of a frame throws away the partial capture mask.
      drive(4'b1110, ~7'h5B, 1'b1, 40, "pre_d0");
      drive(4'b1101, ~7'h07, 1'b1, 40, "pre_d1");
      async_reset("midrst");
      fv_before = fv_pulses;
      drive(4'b1011, ~7'h4F, 1'b1, 40, "post_d2");
      drive(4'b0111, ~7'h66, 1'b1, 40, "post_d3");
      drive(4'b1110, ~7'h77, 1'b1, 40, "post_d0");
      drain();
      chk("post_no_fv_yet", fv_pulses, fv_before);
      drive(4'b1101, ~7'h39, 1'b0, 40, "post_d1");
      drain();
      chk("post_frame_fv", fv_pulses, fv_before + 1);
      chk("post_word", digits_out, 16'h43CA);

      // Long static bus: exactly one capture, no frame.
      fv_before = fv_pulses;
      drive(4'b1110, ~7'h6D, 1'b1, 2000, "static_5");
      drain();
      chk("static_digit0", digits_out[3:0], 4'h5);
      chk("static_no_fv", fv_pulses, fv_before);
      chk("total_fv", fv_pulses, m_fv_count);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan_capture.md
Name: sevenseg_scan_capture

Overview:
- Receive-side counterpart of the Basys3 multiplexed 7-segment display driver.
- Snoops the time-multiplexed anode/segment/dp bus that drives the display and reconstructs the per-digit hex values into registers.
- Used in loopback self-test, where a driver's outputs are wired back in, and as a bench monitor for display drivers.
- Flags patterns that are not valid hex glyphs.

Parameters:
- NUM_DIGITS, 4: number of anodes/digits captured.
- SETTLE_CYCLES, 16: consecutive identical samples required before a digit is captured (range 2..255).
- ACTIVE_LOW, 1: 1 means an/seg/dp inputs are active-low, as on Basys3; 0 means active-high.

Ports:
- clk  in  1  system clock (100 MHz on Basys3).
- rst  in  1  asynchronous, active-high reset.
- an_in  in  NUM_DIGITS  anode enables; bit i selects digit i.
- seg_in  in  7  segments; bit0=a … bit6=g.
- dp_in  in  1  decimal point.
- digits_out  out  4*NUM_DIGITS  decoded nibbles; digit i occupies [4i+3:4i].
- dp_out  out  NUM_DIGITS  captured decimal point per digit (active-high).
- blank_out  out  NUM_DIGITS  1 = digit last captured with all segments off.
- pattern_err  out  NUM_DIGITS  1 = digit last captured with a non-hex glyph.
- multi_an_err  out  1  sticky: a stable sample had more than one anode active.
- frame_valid  out  1  one-cycle pulse when every digit has been captured since the previous pulse.

Behaviour:
- **Reset:** rst asserted clears all outputs, synchronizers, counters and the capture mask to 0, immediately and asynchronously. Mid-operation reset discards any partial frame.
- **Input stage:**
  - 2-flop synchronizer on all NUM_DIGITS+8 input bits.
  - Normalize to active-high: invert when ACTIVE_LOW=1.
- **Stability counter:**
  - cnt increments, saturating at SETTLE_CYCLES, while the normalized sample equals the previous cycle's sample.
  - Any bit change resets cnt to 0 and clears the "captured" flag.
- **Capture event:** fires on the cycle cnt reaches SETTLE_CYCLES-1 with captured=0, then sets captured=1. Exactly one event occurs per stable window.
- **At a capture event:**
  - **No anode active:** nothing stored.
  - **More than one anode active:** multi_an_err set to 1 (sticky until rst); nothing stored.
  - **Exactly one anode i active:**
    - dp_out[i] <= dp.
    - mask[i] <= 1.
    - Segments all off: blank_out[i]=1, pattern_err[i]=0, nibble i = 0.
    - Segments match the hex table: nibble i = value, blank_out[i]=0, pattern_err[i]=0.
    - Otherwise: pattern_err[i]=1, blank_out[i]=0, nibble i retains its previous value.
- **Hex table** (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- **Output registers:** digit outputs update on the clock edge after the capture event.
- **Latency:** 2 (sync) + SETTLE_CYCLES + 1 cycles from an input change to the updated output.
- **Frame completion:**
  - When mask becomes all-ones, frame_valid pulses high for exactly 1 cycle, coincident with the last digit's output update. In the same cycle mask clears to 0.
  - Recapturing an already-captured digit before the frame completes overwrites its value; mask is unchanged.
- **Glitch rejection:** a bus change shorter than SETTLE_CYCLES stable samples never produces a capture.
- **Counter width:** cnt is 8 bits. Saturation prevents wrap-around on long static inputs, so a static bus yields exactly one capture.

Test Plan:
- **Clean scan:** ACTIVE_LOW=1; drive an=1110/seg=~7'h4F (3), 1101/~7'h66 (4), 1011/~7'h7C (b), 0111/~7'h3F (0), 100 cycles each → digits_out=16'h0B43, frame_valid is a single 1-cycle pulse after the 4th digit, pattern_err=0.
- **Latency/settle:** single stable digit 0 with seg=~7'h06 → digits_out[3:0]=1 exactly 19 cycles after the input change. A 10-cycle glitch to seg=~7'h7F in between → no capture of 8.
- **Bad glyph / blank:**
  - digit 2 seg=~7'h7F, then seg=~7'h01 → pattern_err[2]=1, nibble 2 stays 8.
  - digit 1 seg=7'h7F (all off) → blank_out[1]=1, digits_out[7:4]=0.
- **Multi-anode:** an=1100 stable 50 cycles → multi_an_err=1, stays 1 after normal scanning resumes, no digit or mask change.
- **Reset mid-frame:** capture digits 0 and 1, assert rst for 3 cycles (asynchronously, between clock edges) → outputs 0 immediately. Then capture digits 2,3,0,1 → frame_valid pulses only after all four post-reset captures.
- **Static bus:** hold an=1110, seg=~7'h6D for 2000 cycles → exactly one capture, digit 0 = 5, cnt saturates with no recapture and no frame_valid.
